// File: rtl/instr_fetch.sv
// instr_fetch: word fetch from the SPI reader with byte swap, one-entry word buffer and timeout.
module instr_fetch #(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int CNT_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [23:0] fetch_addr,
  input  logic        inval,
  output logic        fetch_valid,
  output logic        fetch_err,
  output logic [31:0] instr,
  output logic [23:0] mem_address,
  output logic        mem_start_fetch,
  input  logic        mem_fetch_done,
  input  logic [31:0] mem_fetched_data
);
  typedef enum logic [2:0] {IDLE, FETCH, RELEASE, DONE, ERR} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic buf_valid;
  logic [21:0] buf_tag;
  logic [31:0] buf_word;
  logic hit, load, timeout;
  logic [31:0] swapped;
  assign swapped = {mem_fetched_data[7:0], mem_fetched_data[15:8],
                    mem_fetched_data[23:16], mem_fetched_data[31:24]};
  // an inval in the same cycle as the request forces a miss
  assign hit = buf_valid && !inval && buf_tag == fetch_addr[23:2];
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign load = state == FETCH && fetch_req && mem_fetch_done;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !fetch_req ? IDLE : |fetch_addr[1:0] ? ERR : hit ? DONE : FETCH;
      FETCH:   state_n = !fetch_req ? IDLE : mem_fetch_done ? RELEASE : timeout ? ERR : FETCH;
      RELEASE: state_n = fetch_req ? DONE : IDLE;
      DONE:    state_n = fetch_req ? DONE : IDLE;
      ERR:     state_n = fetch_req ? ERR : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_err <= 1'b0;
      instr <= '0;
      mem_start_fetch <= 1'b0;
      mem_address <= '0;
      cnt <= '0;
      buf_valid <= 1'b0;
      buf_tag <= '0;
      buf_word <= '0;
    end else begin
      fetch_valid <= state_n == DONE;
      fetch_err <= state_n == ERR;
      mem_start_fetch <= state_n == FETCH;
      cnt <= state == FETCH ? cnt + 1'b1 : '0;
      if (state == IDLE && state_n == FETCH) mem_address <= {fetch_addr[23:2], 2'b00};
      if (load) instr <= swapped;
      else if (state == IDLE && state_n == DONE) instr <= buf_word;
      else if (state_n == ERR) instr <= '0;
      buf_valid <= load ? 1'b1 : inval ? 1'b0 : buf_valid;
      if (load) begin
        buf_word <= swapped;
        buf_tag <= mem_address[23:2];
      end
    end
  end
endmodule
